// File: rtl/sdram_port_pkg.sv
// sdram_port_pkg: shared state encoding, burst lengths and posted-write entry layout
package sdram_port_pkg;
  localparam int BURSTLEN = 8;
  localparam int WRBEATS = 2;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_BEAT1 = 3'd2,
    RD_ISSUE = 3'd3,
    RD_DATA  = 3'd4
  } state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bytesel;
  } wb_entry_t;
  function automatic logic [2:0] last_beat(input logic rd);
    return rd ? 3'(BURSTLEN - 1) : 3'(WRBEATS - 1);
  endfunction
endpackage

// File: rtl/port_write_fifo.sv
// port_write_fifo: posted-write queue of {addr, data, bytesel}; caller never pushes when full or pops when empty
module port_write_fifo
  import sdram_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wdata,
  output wb_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem_q [DEPTH];
  wb_entry_t mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = wdata;
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign rdata = mem_q[rp_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/sdram_cache_port.sv
// sdram_cache_port: arbitrates posted CPU writes and cache line fills onto one SDRAM controller port
module sdram_cache_port
  import sdram_port_pkg::*;
#(
  parameter int WBDEPTH  = 4,
  parameter int ADDRBITS = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cache_req,
  input  logic [31:0]         cache_addr,
  output logic                cache_fill,
  output logic [15:0]         cache_data,
  input  logic                wr_req,
  input  logic [31:0]         wr_addr,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_bytesel,
  output logic                wr_ack,
  output logic                wb_empty,
  output logic                sd_req,
  output logic                sd_rw,
  output logic [ADDRBITS-1:0] sd_addr,
  input  logic                sd_ack,
  output logic [15:0]         sd_wdata,
  output logic [1:0]          sd_dqm,
  input  logic                sd_wrnext,
  input  logic                sd_rdvalid,
  input  logic [15:0]         sd_rdata,
  output logic                error
);
  localparam int CW = $clog2(WBDEPTH) + 1;
  state_t state_q, state_d;
  logic [2:0] beat_q, beat_d;
  logic acked_q, acked_d, wr_ack_q, wr_ack_d, fill_q, fill_d, error_q, error_d;
  logic [15:0] rdata_q, rdata_d;
  logic [ADDRBITS-2:0] rd_addr_q, rd_addr_d;
  logic push, pop, full, empty, in_wr, unused_bits;
  logic [CW-1:0] count;
  wb_entry_t head, entry;
  assign entry = '{addr: wr_addr, data: wr_data, bytesel: wr_bytesel};
  port_write_fifo #(.DEPTH(WBDEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(entry),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // full is the registered count, so a same-cycle pop never admits a write while full
  always_comb begin
    in_wr = state_q == WR_ISSUE || state_q == WR_BEAT1;
    push = wr_req && !full && !wr_ack_q;
    pop = state_q == WR_BEAT1 && sd_wrnext;
    wr_ack_d = push;
    acked_d = state_q == WR_ISSUE && (acked_q || sd_ack);
    state_d = state_q;
    beat_d = beat_q;
    rd_addr_d = rd_addr_q;
    rdata_d = rdata_q;
    fill_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = !empty ? WR_ISSUE : cache_req ? RD_ISSUE : IDLE;
        rd_addr_d = cache_addr[ADDRBITS:2];
      end
      WR_ISSUE: state_d = sd_wrnext ? WR_BEAT1 : WR_ISSUE;
      WR_BEAT1: state_d = sd_wrnext ? IDLE : WR_BEAT1;
      RD_ISSUE: begin
        state_d = sd_ack ? RD_DATA : RD_ISSUE;
        beat_d = '0;
      end
      RD_DATA: if (sd_rdvalid) begin
        rdata_d = sd_rdata;
        fill_d = beat_q == '0;
        beat_d = beat_q + 3'd1;
        state_d = beat_q == last_beat(1'b1) ? IDLE : RD_DATA;
      end
      default: state_d = IDLE;
    endcase
    error_d = error_q || (sd_rdvalid && state_q != RD_DATA) ||
              (state_q == RD_DATA && beat_q != '0 && !sd_rdvalid) || (sd_wrnext && !in_wr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q <= '0;
      acked_q <= 1'b0;
      wr_ack_q <= 1'b0;
      fill_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      acked_q <= acked_d;
      wr_ack_q <= wr_ack_d;
      fill_q <= fill_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      rd_addr_q <= rd_addr_d;
    end
  end
  assign sd_req = (state_q == WR_ISSUE && !acked_q) || state_q == RD_ISSUE;
  assign sd_rw = state_q == RD_ISSUE;
  assign sd_addr = in_wr ? {head.addr[ADDRBITS:2], 1'b0} : sd_rw ? {rd_addr_q, 1'b0} : '0;
  assign sd_wdata = state_q == WR_ISSUE ? head.data[31:16] : state_q == WR_BEAT1 ? head.data[15:0] : '0;
  assign sd_dqm = state_q == WR_ISSUE ? ~head.bytesel[3:2] : state_q == WR_BEAT1 ? ~head.bytesel[1:0] : '0;
  assign wb_empty = count == '0 && !in_wr;
  assign wr_ack = wr_ack_q;
  assign cache_fill = fill_q;
  assign cache_data = rdata_q;
  assign error = error_q;
  assign unused_bits = ^{cache_addr[31:ADDRBITS+1], cache_addr[1:0], head.addr[31:ADDRBITS+1], head.addr[1:0]};
endmodule

// File: tb/tb_sdram_cache_port.sv
// tb_sdram_cache_port: directed scenario bench for the SDRAM cache/write-buffer port
module tb_sdram_cache_port;
  logic clk = 0, reset = 1, cache_req = 0, wr_req = 0, sd_ack = 0, sd_wrnext = 0, sd_rdvalid = 0;
  logic [31:0] cache_addr = 0, wr_addr = 0, wr_data = 0;
  logic [3:0] wr_bytesel = 0;
  logic [15:0] sd_rdata = 0;
  logic cache_fill, wr_ack, wb_empty, sd_req, sd_rw, error;
  logic [15:0] cache_data, sd_wdata;
  logic [24:0] sd_addr;
  logic [1:0] sd_dqm;
  int errors = 0, checks = 0;
  sdram_cache_port #(.WBDEPTH(4), .ADDRBITS(25)) dut (
    .clk(clk), .reset(reset), .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_fill(cache_fill), .cache_data(cache_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_bytesel(wr_bytesel), .wr_ack(wr_ack), .wb_empty(wb_empty),
    .sd_req(sd_req), .sd_rw(sd_rw), .sd_addr(sd_addr), .sd_ack(sd_ack), .sd_wdata(sd_wdata),
    .sd_dqm(sd_dqm), .sd_wrnext(sd_wrnext), .sd_rdvalid(sd_rdvalid), .sd_rdata(sd_rdata),
    .error(error)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset;
    reset = 1;
    tick;
    tick;
    checks++; if ({cache_fill, cache_data, wr_ack, sd_req, sd_rw, sd_addr, sd_wdata, sd_dqm, error} !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", {cache_fill, cache_data, wr_ack, sd_req, sd_rw, sd_addr, sd_wdata, sd_dqm, error}); end
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty: got %b want 1", wb_empty); end
    reset = 0;
    tick;
  endtask
  task automatic test_write;
    wr_req = 1; wr_addr = 32'h100; wr_data = 32'h1234_5678; wr_bytesel = 4'hF;
    tick;
    wr_req = 0;
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_pulse: got %b want 1", wr_ack); end
    checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL wb_empty_queued: got %b want 0", wb_empty); end
    tick;
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_one_cycle: got %b want 0", wr_ack); end
    checks++; if ({sd_req, sd_rw} !== 2'b10) begin errors++; $display("FAIL wr_issue_req_rw: got %b want 10", {sd_req, sd_rw}); end
    checks++; if (sd_addr !== 25'h80) begin errors++; $display("FAIL wr_addr: got %h want 80", sd_addr); end
    checks++; if ({sd_wdata, sd_dqm} !== {16'h1234, 2'b00}) begin errors++; $display("FAIL wr_beat0: got %h/%b want 1234/00", sd_wdata, sd_dqm); end
    sd_ack = 1; sd_wrnext = 1;
    tick;
    sd_ack = 0;
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop: got %b want 0", sd_req); end
    checks++; if ({sd_wdata, sd_dqm} !== {16'h5678, 2'b00}) begin errors++; $display("FAIL wr_beat1: got %h/%b want 5678/00", sd_wdata, sd_dqm); end
    checks++; if (wb_empty !== 1'b0) begin errors++; $display("FAIL wb_empty_inflight: got %b want 0", wb_empty); end
    tick;
    sd_wrnext = 0;
    checks++; if ({wb_empty, error, sd_req} !== 3'b100) begin errors++; $display("FAIL wr_done: got %b want 100", {wb_empty, error, sd_req}); end
  endtask
  task automatic test_bytesel;
    wr_req = 1; wr_addr = 32'h1002; wr_data = 32'hAABB_CCDD; wr_bytesel = 4'b0110;
    tick;
    wr_req = 0;
    tick;
    checks++; if (sd_addr !== 25'h800) begin errors++; $display("FAIL bsel_addr: got %h want 800", sd_addr); end
    checks++; if ({sd_wdata, sd_dqm} !== {16'hAABB, 2'b10}) begin errors++; $display("FAIL bsel_beat0: got %h/%b want aabb/10", sd_wdata, sd_dqm); end
    tick;
    checks++; if (sd_req !== 1'b1) begin errors++; $display("FAIL req_held: got %b want 1", sd_req); end
    sd_ack = 1;
    tick;
    sd_ack = 0;
    checks++; if ({sd_req, sd_wdata} !== {1'b0, 16'hAABB}) begin errors++; $display("FAIL acked_wait: got %b/%h want 0/aabb", sd_req, sd_wdata); end
    sd_wrnext = 1;
    tick;
    checks++; if ({sd_wdata, sd_dqm} !== {16'hCCDD, 2'b01}) begin errors++; $display("FAIL bsel_beat1: got %h/%b want ccdd/01", sd_wdata, sd_dqm); end
    tick;
    sd_wrnext = 0;
    checks++; if (wb_empty !== 1'b1) begin errors++; $display("FAIL bsel_done: got %b want 1", wb_empty); end
  endtask
  task automatic test_back_to_back;
    int acks = 0;
    wr_req = 1; wr_bytesel = 4'hF; wr_addr = 32'h400; wr_data = 32'h00A0_00B0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (wr_ack) begin
        acks++;
        wr_addr = 32'h400 + 32'(acks) * 8;
        wr_data = 32'h00A0_00B0 + 32'(acks) * 32'h0001_0001;
      end
    end
    checks++; if (acks !== 4) begin errors++; $display("FAIL full_acks: got %0d want 4", acks); end
    checks++; if ({sd_req, sd_addr} !== {1'b1, 25'h200}) begin errors++; $display("FAIL stalled_head: got %b/%h want 1/200", sd_req, sd_addr); end
    sd_ack = 1; sd_wrnext = 1;
    tick;
    sd_ack = 0;
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL no_ack_beat1: got %b want 0", wr_ack); end
    tick;
    sd_wrnext = 0;
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL no_ack_on_pop: got %b want 0", wr_ack); end
    tick;
    wr_req = 0;
    checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL fifth_ack: got %b want 1", wr_ack); end
    for (int e = 1; e < 5; e++) begin
      int w = 0;
      while (!sd_req && w < 6) begin tick; w++; end
      checks++; if (sd_req !== 1'b1) begin errors++; $display("FAIL drain_req_%0d: got %b want 1 (timeout)", e, sd_req); end
      checks++; if ({sd_addr, sd_wdata} !== {25'h200 + 25'(e * 4), 16'h00A0 + 16'(e)}) begin errors++; $display("FAIL drain_entry_%0d: got %h/%h want %h/%h", e, sd_addr, sd_wdata, 25'h200 + 25'(e * 4), 16'h00A0 + 16'(e)); end
      sd_ack = 1; sd_wrnext = 1;
      tick;
      sd_ack = 0;
      tick;
      sd_wrnext = 0;
    end
    checks++; if ({wb_empty, error} !== 2'b10) begin errors++; $display("FAIL drained: got %b want 10", {wb_empty, error}); end
  endtask
  task automatic test_read_after_write;
    int fills = 0;
    wr_req = 1; wr_addr = 32'h300; wr_data = 32'hCAFE_F00D; wr_bytesel = 4'hF;
    tick;
    wr_req = 0; cache_req = 1; cache_addr = 32'h208;
    tick;
    checks++; if ({sd_req, sd_rw, sd_addr} !== {2'b10, 25'h180}) begin errors++; $display("FAIL write_first: got %b/%h want 10/180", {sd_req, sd_rw}, sd_addr); end
    sd_ack = 1; sd_wrnext = 1;
    tick;
    sd_ack = 0;
    tick;
    sd_wrnext = 0;
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL idle_between: got %b want 0", sd_req); end
    tick;
    checks++; if ({sd_req, sd_rw, sd_addr} !== {2'b11, 25'h104}) begin errors++; $display("FAIL rd_issue: got %b/%h want 11/104", {sd_req, sd_rw}, sd_addr); end
    sd_ack = 1;
    tick;
    sd_ack = 0;
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b want 0", sd_req); end
    tick;
    for (int i = 0; i < 8; i++) begin
      sd_rdvalid = 1; sd_rdata = 16'h1000 + 16'(i);
      tick;
      if (cache_fill) begin fills++; cache_req = 0; end
      checks++; if ({cache_fill, cache_data} !== {i == 0, 16'h1000 + 16'(i)}) begin errors++; $display("FAIL rd_beat_%0d: got %b/%h want %b/%h", i, cache_fill, cache_data, i == 0, 16'h1000 + 16'(i)); end
    end
    sd_rdvalid = 0;
    tick;
    checks++; if ({fills, cache_fill, error, sd_req} !== {32'd1, 3'b000}) begin errors++; $display("FAIL rd_end: fills=%0d fill=%b err=%b req=%b want 1/0/0/0", fills, cache_fill, error, sd_req); end
  endtask
  task automatic test_error;
    sd_rdvalid = 1;
    tick;
    sd_rdvalid = 0;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_rdvalid_idle: got %b want 1", error); end
    repeat (3) tick;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", error); end
    reset = 1; tick; reset = 0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", error); end
    sd_wrnext = 1;
    tick;
    sd_wrnext = 0;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_wrnext_idle: got %b want 1", error); end
    reset = 1; tick; reset = 0;
    cache_req = 1; cache_addr = 32'h0;
    tick;
    sd_ack = 1;
    tick;
    sd_ack = 0; cache_req = 0; sd_rdvalid = 1;
    tick;
    sd_rdvalid = 0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_first_beat: got %b want 0", error); end
    tick;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_gap: got %b want 1", error); end
    reset = 1; tick; reset = 0;
  endtask
  task automatic test_reset_mid_burst;
    cache_req = 1; cache_addr = 32'h40;
    tick;
    sd_ack = 1;
    tick;
    sd_ack = 0;
    for (int i = 0; i < 3; i++) begin
      sd_rdvalid = 1; sd_rdata = 16'h2000 + 16'(i);
      tick;
      if (i == 0) cache_req = 0;
    end
    sd_rdata = 16'h2003; reset = 1;
    tick;
    reset = 0;
    checks++; if ({wb_empty, cache_fill, sd_req, error} !== 4'b1000) begin errors++; $display("FAIL mid_reset: got %b want 1000", {wb_empty, cache_fill, sd_req, error}); end
    for (int i = 4; i < 8; i++) begin
      sd_rdata = 16'h2000 + 16'(i);
      tick;
      checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL refill_beat_%0d: got %b want 0", i, cache_fill); end
    end
    sd_rdvalid = 0;
    checks++; if ({error, sd_req} !== 2'b10) begin errors++; $display("FAIL stray_beats: got %b want 10", {error, sd_req}); end
  endtask
  initial begin
    test_reset;
    test_write;
    test_bytesel;
    test_back_to_back;
    test_read_after_write;
    test_error;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_cache_port.md
SDRAM_CACHE_PORT -- requirements
Module: sdram_cache_port

Interface
REQ-001 Parameter: WBDEPTH, default 4, posted-write FIFO depth in entries (power of two).
REQ-002 Parameter: ADDRBITS, default 25, SDRAM halfword-address width.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cache_req  in  1  cache line-fill request; the cache holds it until cache_fill.
REQ-006 cache_addr  in  32  byte address of the missed word.
REQ-007 cache_fill  out  1  one-cycle pulse that accompanies the first fill halfword.
REQ-008 cache_data  out  16  fill halfword; 8 beats on consecutive cycles, starting with the cache_fill cycle.
REQ-009 wr_req  in  1  CPU write request.
REQ-010 wr_addr  in  32  write byte address.
REQ-011 wr_data  in  32  write data.
REQ-012 wr_bytesel  in  4  byte enables; bit 3 selects data[31:24].
REQ-013 wr_ack  out  1  one-cycle pulse when the write is captured in the FIFO.
REQ-014 wb_empty  out  1  high when the FIFO is empty and no write is in flight.
REQ-015 sd_req  out  1  controller request; held high until sd_ack.
REQ-016 sd_rw  out  1  1 = read burst of 8, 0 = write of 2 beats.
REQ-017 sd_addr  out  ADDRBITS  halfword start address.
REQ-018 sd_ack  in  1  one-cycle pulse when the controller accepts the request.
REQ-019 sd_wdata  out  16  write halfword.
REQ-020 sd_dqm  out  2  active-high byte masks for sd_wdata.
REQ-021 sd_wrnext  in  1  controller consumed the current write beat.
REQ-022 sd_rdvalid  in  1  read halfword valid.
REQ-023 sd_rdata  in  16  read halfword.
REQ-024 error  out  1  sticky protocol-error flag.

Function
REQ-025 State machine states: IDLE, WR_ISSUE, WR_BEAT1, RD_ISSUE, RD_DATA.
REQ-026 A write is captured when wr_req=1, the FIFO is not full at the start of the cycle, and no wr_ack was given in the previous cycle; wr_ack is asserted the following cycle.
REQ-027 When the FIFO is full, wr_ack is withheld; a push and a pop in the same cycle are never combined to admit a write while full.
REQ-028 IDLE with a FIFO entry present -> WR_ISSUE; writes have priority over reads.
REQ-029 IDLE with the FIFO empty and cache_req=1 -> RD_ISSUE; a read is never issued while any write is queued or in flight.
REQ-030 WR_ISSUE: sd_req=1, sd_rw=0, sd_addr={wr_addr[ADDRBITS:2],1'b0}, sd_wdata=data[31:16], sd_dqm=~bytesel[3:2].
REQ-031 WR_ISSUE: sd_wrnext -> WR_BEAT1 with sd_wdata=data[15:0] and sd_dqm=~bytesel[1:0].
REQ-032 WR_BEAT1: sd_wrnext pops the FIFO entry and returns to IDLE.
REQ-033 sd_req drops in the cycle after sd_ack; sd_wrnext may coincide with sd_ack.
REQ-034 RD_ISSUE latches cache_addr and drives sd_rw=1, sd_addr={cache_addr[ADDRBITS:2],1'b0}; the controller wraps the burst within the aligned 8-halfword line, critical word first.
REQ-035 RD_ISSUE with sd_ack -> RD_DATA; the 3-bit beat counter is cleared.
REQ-036 RD_DATA registers each sd_rdvalid beat to cache_data with 1-cycle latency; cache_fill=1 only on beat 0.
REQ-037 After beat 7 the machine returns to IDLE; a read-to-write turnaround costs 1 IDLE cycle.
REQ-038 error is set by any of: sd_rdvalid outside RD_DATA; a gap between read beats; sd_wrnext outside WR_ISSUE/WR_BEAT1.
REQ-039 error clears only on reset.
REQ-040 wb_empty = (FIFO count==0) and state not in {WR_ISSUE, WR_BEAT1}.

Reset
REQ-041 Reset forces IDLE and empties the FIFO.
REQ-042 At reset, every output is 0 except wb_empty, which is 1.
REQ-043 A reset mid-burst or mid-write abandons the transaction; any following sd_rdvalid or sd_wrnext sets error.

Structure
REQ-044 Package sdram_port_pkg holds the state enum, BURSTLEN=8 and WRBEATS=2.
REQ-045 A single sub-module, port_write_fifo, holds {addr, data, bytesel} with push, pop, full, empty and count.

Verification
REQ-046 Write 0x12345678 to 0x100, bytesel 1111 -> sd_addr 0x80; beats 0x1234 then 0x5678; dqm 00 on both beats.
REQ-047 Five back-to-back writes with the controller stalled -> 4 wr_acks; the 5th wr_ack follows the first sd_wrnext pop.
REQ-048 cache_req at 0x208 while one write is queued -> write issued first; read sd_addr 0x104; 8 beats with cache_fill on beat 0 only.
REQ-049 sd_rdvalid pulsed in IDLE -> error=1, held until reset.
REQ-050 Reset asserted on read beat 3 -> IDLE, wb_empty=1; remaining beats set error; cache_fill is not re-asserted.
